// File: rtl/matinv_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matinv_seq_pkg
// Description : Shared types and constants for the matinv sequencing
//               controller. Includes FSM state encoding, default widths and
//               the register-file indices of the controller's registers.
// Revision    : 1.0 - initial release
// ============================================================================
package matinv_seq_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    NEXT   = 2'd3
  } state_e;

  // Default widths
  localparam int c_CNT_W = 32;
  localparam int c_RUN_W = 8;

  // AXI register file word indices
  localparam int c_REG_CTRL   = 4;
  localparam int c_REG_STATUS = 5;
  localparam int c_REG_RETURN = 6;
  localparam int c_REG_CYCLES = 7;
  localparam int c_REG_FAIL   = 8;

endpackage : matinv_seq_pkg
`default_nettype wire

// File: rtl/matinv_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : matinv_seq_ctrl
// Description : Drives the HLS matinv core through its ap_ctrl_hs handshake.
//               A rising edge on start_lvl launches max(run_count,1)
//               back-to-back runs. Per run, the block captures ap_return and
//               latency, and counts non-zero returns. host_lock marks the
//               matrix RAMs as owned by the core for the whole batch.
//               Optional feature macro: MATINV_SEQ_TIMEOUT_EN (per-run abort
//               after TIMEOUT cycles; otherwise timeout is tied to 0).
// Revision    : 1.0 - initial release
// ============================================================================
module matinv_seq_ctrl
    import matinv_seq_pkg::*;
#(
    parameter int CNT_W   = c_CNT_W,
    parameter int RUN_W   = c_RUN_W,
    parameter int TIMEOUT = 65536
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             start_lvl,
    input  logic             clr,
    input  logic [RUN_W-1:0] run_count,
    output logic             ap_start,
    input  logic             ap_done,
    input  logic             ap_idle,
    input  logic             ap_ready,
    input  logic [31:0]      ap_return,
    output logic             busy,
    output logic             host_lock,
    output logic             done,
    output logic [31:0]      last_return,
    output logic [RUN_W-1:0] fail_count,
    output logic [CNT_W-1:0] cycles,
    output logic             timeout
);

    state_e           r_state;
    logic             r_start_q;
    logic             r_pend;
    logic [RUN_W-1:0] r_runs_left;
    logic [RUN_W-1:0] r_fail;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_cycles;
    logic [31:0]      r_last;
    logic             r_ap_start;
    logic             r_busy;
    logic             r_done;
    logic             r_timeout;

    logic w_start_req;
    logic w_launch;
    logic w_relaunch;
    logic w_in_run;
    logic w_run_done;
    logic w_tmo;

    assign w_start_req = start_lvl & ~r_start_q;
    // A request seen while the core is still busy is held until ap_idle rises
    assign w_launch    = (r_state == IDLE) && (w_start_req || r_pend) && ap_idle;
    assign w_relaunch  = (r_state == NEXT) && (r_runs_left != RUN_W'(1));
    assign w_in_run    = (r_state == LAUNCH) || (r_state == WAIT);
    // Ready and done in the same LAUNCH cycle completes the run immediately
    assign w_run_done  = ((r_state == LAUNCH) && ap_ready && ap_done) ||
                         ((r_state == WAIT) && ap_done);

`ifdef MATINV_SEQ_TIMEOUT_EN
    // A run completing on the limit cycle counts as completed, not aborted
    assign w_tmo = w_in_run && !w_run_done && (r_cnt == CNT_W'(TIMEOUT));
`else
    assign w_tmo = 1'b0;
`endif

    // Delay start_lvl by one cycle for rising-edge detection
    always_ff @(posedge ap_clk) begin
        if (ap_rst) r_start_q <= 1'b0;
        else        r_start_q <= start_lvl;
    end

    // Run latency counter: 1 in the first ap_start cycle, saturating
    always_ff @(posedge ap_clk) begin
        if (ap_rst)                         r_cnt <= '0;
        else if (w_launch || w_relaunch)    r_cnt <= CNT_W'(1);
        else if (w_in_run && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
    end

    // Saturating count of non-zero returns; clr has priority over increment
    always_ff @(posedge ap_clk) begin
        if (ap_rst)               r_fail <= '0;
        else if (clr || w_launch) r_fail <= '0;
        else if (w_run_done && (ap_return != 32'd0) && (r_fail != '1))
                                  r_fail <= r_fail + RUN_W'(1);
    end

    // Batch sequencer with registered handshake and status outputs
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state     <= IDLE;
            r_pend      <= 1'b0;
            r_runs_left <= '0;
            r_cycles    <= '0;
            r_last      <= '0;
            r_ap_start  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_launch) begin
                        r_state     <= LAUNCH;
                        r_pend      <= 1'b0;
                        r_runs_left <= (run_count == '0) ? RUN_W'(1) : run_count;
                        r_cycles    <= '0;
                        r_done      <= 1'b0;
                        r_busy      <= 1'b1;
                        r_ap_start  <= 1'b1;
                    end else if (w_start_req) begin
                        r_pend <= 1'b1;
                    end
                end
                LAUNCH: begin
                    if (w_run_done) begin
                        r_state    <= NEXT;
                        r_ap_start <= 1'b0;
                    end else if (w_tmo) begin
                        r_state    <= IDLE;
                        r_ap_start <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_timeout  <= 1'b1;
                    end else if (ap_ready) begin
                        r_state    <= WAIT;
                        r_ap_start <= 1'b0;
                    end
                end
                WAIT: begin
                    if (w_run_done) begin
                        r_state <= NEXT;
                    end else if (w_tmo) begin
                        r_state   <= IDLE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                    end
                end
                NEXT: begin
                    r_runs_left <= r_runs_left - RUN_W'(1);
                    if (w_relaunch) begin
                        r_state    <= LAUNCH;
                        r_ap_start <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_run_done) begin
                r_last   <= ap_return;
                r_cycles <= r_cnt;
            end

            // Software clear overrides any same-cycle status update
            if (clr) begin
                r_done    <= 1'b0;
                r_timeout <= 1'b0;
            end
        end
    end

    assign ap_start    = r_ap_start;
    assign busy        = r_busy;
    assign host_lock   = r_busy;
    assign done        = r_done;
    assign last_return = r_last;
    assign fail_count  = r_fail;
    assign cycles      = r_cycles;
    assign timeout     = r_timeout;

endmodule : matinv_seq_ctrl
`default_nettype wire

// File: tb/tb_matinv_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_matinv_seq_ctrl
// Description : Directed self-checking bench for matinv_seq_ctrl with a
//               behavioural ap_ctrl_hs core model of programmable latency.
//               Timeout scenario runs when MATINV_SEQ_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matinv_seq_ctrl;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        start_lvl;
    logic        clr;
    logic [7:0]  run_count;
    logic        ap_start;
    logic        ap_done;
    logic        ap_idle;
    logic        ap_ready;
    logic [31:0] ap_return;
    logic        busy;
    logic        host_lock;
    logic        done;
    logic [31:0] last_return;
    logic [7:0]  fail_count;
    logic [31:0] cycles;
    logic        timeout;

    int n_chk  = 0;
    int n_fail = 0;

    // Core model state
    int          m_lat       = 20;
    logic        m_hang      = 1'b0;
    logic        m_hold_idle = 1'b0;
    logic        m_busy      = 1'b0;
    int          m_cnt       = 0;
    logic [1:0]  m_idx       = 2'd0;
    logic [31:0] m_ret [4];

    // ap_start activity monitor
    int   n_rise = 0;
    int   n_hi   = 0;
    logic r_prev = 1'b0;

    always #5 ap_clk = ~ap_clk;

    matinv_seq_ctrl #(.CNT_W(32), .RUN_W(8), .TIMEOUT(100)) u_dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .start_lvl   (start_lvl),
        .clr         (clr),
        .run_count   (run_count),
        .ap_start    (ap_start),
        .ap_done     (ap_done),
        .ap_idle     (ap_idle),
        .ap_ready    (ap_ready),
        .ap_return   (ap_return),
        .busy        (busy),
        .host_lock   (host_lock),
        .done        (done),
        .last_return (last_return),
        .fail_count  (fail_count),
        .cycles      (cycles),
        .timeout     (timeout)
    );

    // Core: ready when accepting; done m_lat cycles after the accept cycle,
    // or combinationally with the accept when m_lat is 0
    assign ap_ready  = ap_start & ~m_busy;
    assign ap_done   = ~m_hang & ((m_lat == 0) ? (ap_start & ~m_busy)
                                               : (m_busy && (m_cnt == m_lat)));
    assign ap_idle   = ~m_busy & ~m_hold_idle;
    assign ap_return = m_ret[m_idx];

    always @(posedge ap_clk) begin
        if (ap_rst) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
            m_idx  <= 2'd0;
        end else begin
            if (!busy)        m_idx <= 2'd0;
            else if (ap_done) m_idx <= m_idx + 2'd1;
            if (m_busy) begin
                if (ap_done) m_busy <= 1'b0;
                else         m_cnt  <= m_cnt + 1;
            end else if (ap_start && ap_ready && (m_lat != 0)) begin
                m_busy <= 1'b1;
                m_cnt  <= 1;
            end
        end
    end

    always @(negedge ap_clk) begin
        if (ap_start === 1'b1) n_hi++;
        if ((ap_start === 1'b1) && (r_prev !== 1'b1)) n_rise++;
        r_prev = ap_start;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 3000 && done !== 1'b1; k++) @(negedge ap_clk);
        chk({tag, "_done"}, done, 1);
    endtask

    task automatic batch(input logic [7:0] rc, input int lat, input string tag);
        run_count = rc;
        m_lat     = lat;
        @(negedge ap_clk) start_lvl = 1'b1;
        @(negedge ap_clk) start_lvl = 1'b0;
        wait_done(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, h0, k;
        ap_rst = 1'b1; start_lvl = 1'b0; clr = 1'b0; run_count = 8'd1;
        for (int i = 0; i < 4; i++) m_ret[i] = 32'd0;
        repeat (3) @(negedge ap_clk);
        chk("rst_busy",   busy, 0);
        chk("rst_start",  ap_start, 0);
        chk("rst_done",   done, 0);
        chk("rst_cycles", cycles, 0);
        chk("rst_fail",   fail_count, 0);
        chk("rst_tmo",    timeout, 0);
        @(negedge ap_clk) ap_rst = 1'b0;
        @(negedge ap_clk);

        // Single run, 20-cycle core
        r0 = n_rise; h0 = n_hi;
        batch(8'd1, 20, "single");
        chk("single_hi",     n_hi - h0, 1);
        chk("single_rise",   n_rise - r0, 1);
        chk("single_cycles", cycles, 21);
        chk("single_busy",   busy, 0);
        chk("single_lock",   host_lock, 0);

        // Batch of three, returns 0,5,0
        m_ret[0] = 32'd0; m_ret[1] = 32'd5; m_ret[2] = 32'd0;
        r0 = n_rise; h0 = n_hi;
        batch(8'd3, 3, "batch");
        chk("batch_rise",   n_rise - r0, 3);
        chk("batch_hi",     n_hi - h0, 3);
        chk("batch_fail",   fail_count, 1);
        chk("batch_last",   last_return, 0);
        chk("batch_cycles", cycles, 4);

        // clr pulse
        @(negedge ap_clk) clr = 1'b1;
        @(negedge ap_clk) clr = 1'b0;
        chk("clr_done", done, 0);
        chk("clr_fail", fail_count, 0);
        chk("clr_busy", busy, 0);

        // run_count 0 behaves as one run
        m_ret[0] = 32'd7;
        r0 = n_rise;
        batch(8'd0, 5, "rc0");
        chk("rc0_rise",   n_rise - r0, 1);
        chk("rc0_fail",   fail_count, 1);
        chk("rc0_last",   last_return, 7);
        chk("rc0_cycles", cycles, 6);

        // Same-cycle ready and done
        m_ret[0] = 32'd9;
        r0 = n_rise; h0 = n_hi;
        batch(8'd1, 0, "same");
        chk("same_cycles", cycles, 1);
        chk("same_rise",   n_rise - r0, 1);
        chk("same_hi",     n_hi - h0, 1);
        chk("same_last",   last_return, 9);

        // Reset mid-batch, start held through reset
        m_ret[0] = 32'h33; run_count = 8'd1; m_lat = 20;
        @(negedge ap_clk) start_lvl = 1'b1;
        @(negedge ap_clk) start_lvl = 1'b0;
        repeat (3) @(negedge ap_clk);
        chk("mid_busy", busy, 1);
        ap_rst = 1'b1; start_lvl = 1'b1;
        @(negedge ap_clk);
        chk("mrst_busy",  busy, 0);
        chk("mrst_start", ap_start, 0);
        chk("mrst_last",  last_return, 0);
        chk("mrst_lock",  host_lock, 0);
        @(negedge ap_clk) ap_rst = 1'b0;
        @(negedge ap_clk);
        chk("held_busy",  busy, 1);
        chk("held_start", ap_start, 1);
        start_lvl = 1'b0;
        wait_done("held");
        chk("held_last", last_return, 32'h33);

        // Core not idle: launch waits for ap_idle
        m_ret[0] = 32'd0; m_hold_idle = 1'b1; run_count = 8'd1; m_lat = 2;
        @(negedge ap_clk) start_lvl = 1'b1;
        @(negedge ap_clk) start_lvl = 1'b0;
        repeat (4) @(negedge ap_clk);
        chk("idle_hold_busy",  busy, 0);
        chk("idle_hold_start", ap_start, 0);
        m_hold_idle = 1'b0;
        @(negedge ap_clk);
        chk("idle_rel_busy", busy, 1);
        wait_done("idle");
        chk("idle_cycles", cycles, 3);

        // start_lvl held and re-pulsed mid-batch: exactly one batch
        m_ret[0] = 32'd0; m_ret[1] = 32'd0; run_count = 8'd2; m_lat = 10;
        r0 = n_rise;
        @(negedge ap_clk) start_lvl = 1'b1;
        repeat (5) @(negedge ap_clk);
        start_lvl = 1'b0;
        @(negedge ap_clk) start_lvl = 1'b1;
        wait_done("hold");
        repeat (5) @(negedge ap_clk);
        chk("hold_rise", n_rise - r0, 2);
        chk("hold_busy", busy, 0);
        chk("hold_fail", fail_count, 0);
        start_lvl = 1'b0;

`ifdef MATINV_SEQ_TIMEOUT_EN
        // Core never finishes: abort at counter value 100
        m_hang = 1'b1; run_count = 8'd3; m_lat = 5;
        @(negedge ap_clk) start_lvl = 1'b1;
        @(negedge ap_clk) start_lvl = 1'b0;
        k = 1;
        while (done !== 1'b1 && k < 300) begin
            @(negedge ap_clk);
            k++;
        end
        chk("tmo_cycle", k, 101);
        chk("tmo_flag",  timeout, 1);
        chk("tmo_done",  done, 1);
        chk("tmo_busy",  busy, 0);
        chk("tmo_start", ap_start, 0);
        chk("tmo_last",  last_return, 0);
        @(negedge ap_clk) clr = 1'b1;
        @(negedge ap_clk) clr = 1'b0;
        chk("tmo_clr", timeout, 0);
`else
        k = 0;
        chk("no_tmo_flag", timeout, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule : tb_matinv_seq_ctrl
`default_nettype wire
